// File: rtl/uart_cmd_pkg.sv
// Shared state encoding and constants for the UART command parser.
package uart_cmd_pkg;

    localparam int OPC_W = 8;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_OPERAND = 4'b0010,
        S_OPCODE  = 4'b0100,
        S_COMMIT  = 4'b1000
    } cmd_state_t;

    // The inter-byte timer only runs while a frame is partially received.
    function automatic logic in_frame(input cmd_state_t s);
        return (s == S_OPERAND) || (s == S_OPCODE);
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Clearable inter-byte timeout counter; expired is asserted in the cycle the
// next increment would reach TIMEOUT_CYC, so the owner's registered flag lands on that edge.
module uart_byte_timer #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_s;
            assign unused_s = clear ^ enable;
            assign expired  = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYC + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
            logic [CW-1:0] count_r;

            // Idle-cycle counter, restarted by every accepted byte and held at zero outside a frame.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    count_r <= '0;
                end else if (clear || !enable) begin
                    count_r <= '0;
                end else begin
                    count_r <= count_r + CW'(1'b1);
                end
            end

            assign expired = enable && !clear && (count_r == LAST);
        end
    endgenerate

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles NOPS operands of OPW bits plus an opcode byte from a UART byte
// stream into one command held on a valid/ready output.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int OPW         = 16,
    parameter int NOPS        = 2,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 rx_ready,
    input  logic [7:0]           rx_data,
    output logic [NOPS*OPW-1:0]  operands,
    output logic [OPC_W-1:0]     opcode,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 drop,
    output logic                 timeout_err,
    output logic [3:0]           state_id
);

    localparam int AW = NOPS * OPW;
    localparam int NB = AW / 8;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] NB_C = CW'(NB);
    localparam cmd_state_t FIRST_NEXT = (NB == 1) ? S_OPCODE : S_OPERAND;

    cmd_state_t          state_r;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_inc_s;
    logic [AW-1:0]       asm_r;
    logic [AW-1:0]       asm_shift_s;
    logic [AW-1:0]       operands_r;
    logic [OPC_W-1:0]    opc_stage_r;
    logic [OPC_W-1:0]    opcode_r;
    logic                cmd_valid_r;
    logic                drop_r;
    logic                timeout_err_r;
    logic                expired_s;
    logic                timer_en_s;

    assign asm_shift_s = (asm_r << 4'd8) | AW'(rx_data);
    assign cnt_inc_s   = cnt_r + CW'(1'b1);
    assign timer_en_s  = in_frame(state_r);

    uart_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (rx_ready),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // Frame FSM, staging registers and the held command slot.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r       <= S_IDLE;
            cnt_r         <= '0;
            asm_r         <= '0;
            opc_stage_r   <= '0;
            operands_r    <= '0;
            opcode_r      <= '0;
            cmd_valid_r   <= 1'b0;
            drop_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            drop_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            if (cmd_valid_r && cmd_ready) begin
                cmd_valid_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    if (rx_ready) begin
                        asm_r   <= asm_shift_s;
                        cnt_r   <= CW'(1'b1);
                        state_r <= FIRST_NEXT;
                    end
                end
                S_OPERAND: begin
                    if (rx_ready) begin
                        asm_r <= asm_shift_s;
                        cnt_r <= cnt_inc_s;
                        if (cnt_inc_s == NB_C) begin
                            state_r <= S_OPCODE;
                        end
                    end else if (expired_s) begin
                        timeout_err_r <= 1'b1;
                        cnt_r         <= '0;
                        state_r       <= S_IDLE;
                    end
                end
                S_OPCODE: begin
                    if (rx_ready) begin
                        opc_stage_r <= rx_data;
                        state_r     <= S_COMMIT;
                    end else if (expired_s) begin
                        timeout_err_r <= 1'b1;
                        cnt_r         <= '0;
                        state_r       <= S_IDLE;
                    end
                end
                S_COMMIT: begin
                    // A slot being consumed this very cycle can take the new command.
                    if (!cmd_valid_r || cmd_ready) begin
                        operands_r  <= asm_r;
                        opcode_r    <= opc_stage_r;
                        cmd_valid_r <= 1'b1;
                    end else begin
                        drop_r <= 1'b1;
                    end
                    if (rx_ready) begin
                        asm_r   <= asm_shift_s;
                        cnt_r   <= CW'(1'b1);
                        state_r <= FIRST_NEXT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign operands    = operands_r;
    assign opcode      = opcode_r;
    assign cmd_valid   = cmd_valid_r;
    assign drop        = drop_r;
    assign timeout_err = timeout_err_r;
    assign state_id    = state_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized self-checking bench for uart_cmd_parser with a frame-level reference model.
module tb_uart_cmd_parser;

    localparam int OPW = 16;
    localparam int NOPS = 2;
    localparam int TMO = 1000;
    localparam int NB = NOPS * OPW / 8;

    logic                clock = 1'b0;
    logic                resetn = 1'b0;
    logic                rx_ready = 1'b0;
    logic [7:0]          rx_data = 8'h00;
    logic                cmd_ready = 1'b0;
    logic [NOPS*OPW-1:0] operands;
    logic [7:0]          opcode;
    logic                cmd_valid;
    logic                drop;
    logic                timeout_err;
    logic [3:0]          state_id;

    logic       rx_ready8 = 1'b0;
    logic [7:0] rx_data8 = 8'h00;
    logic       cmd_ready8 = 1'b0;
    logic [7:0] operands8;
    logic [7:0] opcode8;
    logic       cmd_valid8;
    logic       drop8;
    logic       timeout_err8;
    logic [3:0] state_id8;

    int n_tests = 0;
    int n_fail = 0;
    int saw_operand8 = 0;

    // Model of the single output slot.
    logic              m_valid;
    logic [8*NB-1:0]   m_ops;
    logic [7:0]        m_opc;
    logic [7:0]        fb [0:15];

    uart_cmd_parser #(.OPW(OPW), .NOPS(NOPS), .TIMEOUT_CYC(TMO)) u_dut (
        .clock(clock), .resetn(resetn), .rx_ready(rx_ready), .rx_data(rx_data),
        .operands(operands), .opcode(opcode), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .drop(drop), .timeout_err(timeout_err), .state_id(state_id)
    );

    uart_cmd_parser #(.OPW(8), .NOPS(1), .TIMEOUT_CYC(TMO)) u_dut8 (
        .clock(clock), .resetn(resetn), .rx_ready(rx_ready8), .rx_data(rx_data8),
        .operands(operands8), .opcode(opcode8), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
        .drop(drop8), .timeout_err(timeout_err8), .state_id(state_id8)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (state_id8 == 4'b0010) saw_operand8++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic set_frame5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4;
    endtask

    // Sends nsend bytes of fb; a full frame is checked for commit/drop, a partial one for timeout.
    task automatic run_frame(input int nsend, input logic r, input logic rc, input int gap);
        logic [8*NB-1:0] ops;
        logic            exp_drop;
        ops = '0;
        cmd_ready = r;
        if (r) m_valid = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            if (i > 0) repeat (gap) tick();
            send_byte(fb[i]);
            if (i < NB) ops = {ops[8*NB-9:0], fb[i]};
            if (i == 0) check_eq("state_first", state_id, 4'b0010);
            if (i == NB - 1) check_eq("state_opcode", state_id, 4'b0100);
        end
        if (nsend == NB + 1) begin
            check_eq("state_commit", state_id, 4'b1000);
            check_eq("valid_in_commit", cmd_valid, m_valid);
            cmd_ready = rc;
            exp_drop = m_valid && !rc;
            tick();
            check_eq("state_after_commit", state_id, 4'b0001);
            check_eq("drop", drop, exp_drop);
            if (!exp_drop) begin
                m_valid = 1'b1;
                m_ops = ops;
                m_opc = fb[NB];
            end
            check_eq("cmd_valid", cmd_valid, 1'b1);
            check_eq("operands", operands, m_ops);
            check_eq("opcode", opcode, m_opc);
            tick();
            check_eq("drop_one_cycle", drop, 1'b0);
            if (rc) m_valid = 1'b0;
            check_eq("cmd_valid_after", cmd_valid, m_valid);
        end else begin
            repeat (TMO - 1) tick();
            check_eq("no_early_timeout", timeout_err, 1'b0);
            check_eq("still_in_frame", state_id == 4'b0001, 1'b0);
            tick();
            check_eq("timeout_err", timeout_err, 1'b1);
            check_eq("state_after_timeout", state_id, 4'b0001);
            tick();
            check_eq("timeout_one_cycle", timeout_err, 1'b0);
            check_eq("cmd_valid_kept", cmd_valid, m_valid);
        end
    endtask

    initial begin
        int nsend;
        logic r;
        logic rc;
        m_valid = 1'b0;
        m_ops = '0;
        m_opc = 8'h00;

        repeat (3) tick();
        check_eq("rst_operands", operands, 32'h0);
        check_eq("rst_opcode", opcode, 8'h00);
        check_eq("rst_valid", cmd_valid, 1'b0);
        check_eq("rst_drop", drop, 1'b0);
        check_eq("rst_timeout", timeout_err, 1'b0);
        check_eq("rst_state", state_id, 4'b0001);
        resetn = 1'b1;
        tick();

        // Basic frame, consumer always ready.
        set_frame5(8'h12, 8'h34, 8'h56, 8'h78, 8'h03);
        run_frame(5, 1'b1, 1'b1, 20);

        // Slot full: second frame is dropped, then the first is consumed.
        set_frame5(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01);
        run_frame(5, 1'b0, 1'b0, 20);
        set_frame5(8'h11, 8'h22, 8'h33, 8'h44, 8'h02);
        run_frame(5, 1'b0, 1'b0, 20);
        check_eq("held_ops", operands, 32'hAABBCCDD);
        cmd_ready = 1'b1;
        tick();
        m_valid = 1'b0;
        check_eq("held_consumed", cmd_valid, 1'b0);

        // Partial frame times out, next frame parses.
        set_frame5(8'h12, 8'h34, 8'h00, 8'h00, 8'h00);
        run_frame(2, 1'b1, 1'b1, 20);
        set_frame5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
        run_frame(5, 1'b1, 1'b1, 20);

        // Consumer accepts exactly in the COMMIT cycle of a new frame.
        set_frame5(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h07);
        run_frame(5, 1'b0, 1'b0, 20);
        set_frame5(8'h55, 8'h66, 8'h77, 8'h88, 8'h09);
        run_frame(5, 1'b0, 1'b1, 20);

        // Next frame's first byte arrives during COMMIT.
        cmd_ready = 1'b1;
        tick();
        m_valid = 1'b0;
        set_frame5(8'h21, 8'h43, 8'h65, 8'h87, 8'h0A);
        for (int i = 0; i < 5; i++) send_byte(fb[i]);
        send_byte(8'hA1);
        check_eq("b2b_state", state_id, 4'b0010);
        check_eq("b2b_valid", cmd_valid, 1'b1);
        check_eq("b2b_ops1", operands, 32'h21436587);
        check_eq("b2b_opc1", opcode, 8'h0A);
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        send_byte(8'hA5);
        check_eq("b2b_commit", state_id, 4'b1000);
        tick();
        check_eq("b2b_valid2", cmd_valid, 1'b1);
        check_eq("b2b_ops2", operands, 32'hA1A2A3A4);
        check_eq("b2b_opc2", opcode, 8'hA5);
        tick();
        m_valid = 1'b0;

        // Asynchronous reset mid-frame with a command held.
        set_frame5(8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5);
        run_frame(5, 1'b0, 1'b0, 3);
        send_byte(8'h9A);
        send_byte(8'h9B);
        send_byte(8'h9C);
        @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check_eq("arst_operands", operands, 32'h0);
        check_eq("arst_opcode", opcode, 8'h00);
        check_eq("arst_valid", cmd_valid, 1'b0);
        check_eq("arst_state", state_id, 4'b0001);
        m_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        set_frame5(8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B);
        run_frame(5, 1'b0, 1'b0, 5);

        // Randomized frames, ready patterns, gaps and timeouts.
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i <= NB; i++) fb[i] = 8'($urandom_range(0, 255));
            nsend = ($urandom_range(0, 4) == 0) ? $urandom_range(1, NB) : NB + 1;
            r = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_frame(nsend, r, rc, $urandom_range(0, 25));
            repeat ($urandom_range(0, 5)) tick();
        end

        // Single one-byte operand: OPERAND state is skipped.
        rx_data8 = 8'hAA;
        rx_ready8 = 1'b1;
        tick();
        rx_ready8 = 1'b0;
        check_eq("n1_state_opcode", state_id8, 4'b0100);
        repeat (5) tick();
        rx_data8 = 8'h05;
        rx_ready8 = 1'b1;
        tick();
        rx_ready8 = 1'b0;
        check_eq("n1_state_commit", state_id8, 4'b1000);
        tick();
        check_eq("n1_valid", cmd_valid8, 1'b1);
        check_eq("n1_operands", operands8, 8'hAA);
        check_eq("n1_opcode", opcode8, 8'h05);
        check_eq("n1_no_operand_state", saw_operand8, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Parametrised command assembler that sits directly behind `uart_basic` on the receive side. It collects `NOPS` operands of `OPW` bits and a one-byte opcode from the byte stream, then presents them as one command on a valid/ready output held until consumed. It adds an inter-byte timeout, overflow reporting and a one-hot state export for board LEDs. It replaces the fixed two-operand, one-shot-trigger receive controller in calculator-style tops.

## Interface

Parameters:

- `OPW`, 16: operand width in bits; a multiple of 8, minimum 8.
- `NOPS`, 2: number of operands per command; minimum 1.
- `TIMEOUT_CYC`, 1_000_000: idle clock cycles allowed between bytes inside a frame (10 ms at 100 MHz). 0 disables the timeout.

Ports:

- `clock`  in  1  system clock, 100 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `rx_ready`  in  1  one-cycle pulse; `rx_data` is valid in that cycle.
- `rx_data`  in  8  received byte.
- `operands`  out  NOPS*OPW  assembled operands; operand 0 occupies the most-significant slice.
- `opcode`  out  8  command opcode.
- `cmd_valid`  out  1  a command is held on `operands`/`opcode`.
- `cmd_ready`  in  1  consumer accepts the command when high together with `cmd_valid`.
- `drop`  out  1  one-cycle pulse; a completed command was discarded because the output slot was full.
- `timeout_err`  out  1  one-cycle pulse; a partial frame was discarded because of the timeout.
- `state_id`  out  4  one-hot state: bit0 IDLE, bit1 OPERAND, bit2 OPCODE, bit3 COMMIT.

## Operation

- Frame format: NB = NOPS*OPW/8 operand bytes, MSB first with operand 0 first, followed by 1 opcode byte.
- Assembly register: NB*8 bits. Each operand byte shifts in from the LSB side (`asm <= {asm, rx_data}`). Byte counter width is $clog2(NB+1).
- IDLE: on `rx_ready`, shift the byte in and set cnt=1.
  - Next state is OPCODE if NB==1, else OPERAND.
- OPERAND: on `rx_ready`, shift the byte in and increment cnt.
  - When cnt reaches NB on this byte, go to OPCODE.
- OPCODE: on `rx_ready`, capture `rx_data` into the opcode staging register and go to COMMIT.
- COMMIT (exactly 1 cycle), then go to IDLE:
  - If `!cmd_valid || cmd_ready`: load `operands`/`opcode` from staging and set `cmd_valid`.
  - Else: pulse `drop`; outputs are unchanged.
- An `rx_ready` arriving in COMMIT is processed as the first byte of the next frame, exactly as in IDLE.
- Timeout (OPERAND and OPCODE states only):
  - The cycle counter clears on every accepted byte and on entering those states.
  - When it reaches TIMEOUT_CYC: pulse `timeout_err`, go to IDLE, clear cnt. Staging contents are don't-care.
  - If `rx_ready` arrives in the same cycle the timeout fires, the byte wins and the counter clears.
- Output handshake: `cmd_valid` clears on the `cmd_valid && cmd_ready` edge unless COMMIT reloads it in that same cycle.
  - `operands` and `opcode` are stable while `cmd_valid` is high.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; cnt, timer and staging clear.
  - `operands`=0, `opcode`=0, `cmd_valid`=0, `drop`=0, `timeout_err`=0, `state_id`=4'b0001.

## Timing

- Opcode byte sampled at edge E. COMMIT occupies cycle E..E+1. `cmd_valid` is high from edge E+1: 2-cycle latency measured from the `rx_ready` cycle.
- `drop` is high during the cycle after the COMMIT edge, for exactly 1 cycle.
- `timeout_err` is high for exactly 1 cycle, beginning TIMEOUT_CYC cycles after the last accepted byte's edge.
- `state_id` is registered and matches the current state with no extra delay.
- No combinational path from `cmd_ready` to any output.

## Structure

- `uart_cmd_pkg` holds:
  - `typedef enum logic [3:0] {S_IDLE=4'b0001, S_OPERAND=4'b0010, S_OPCODE=4'b0100, S_COMMIT=4'b1000} cmd_state_t`
  - the opcode width constant (8).
- The state register drives `state_id` directly.
- One sub-module, `uart_byte_timer`: the clearable timeout counter.
  - Parameter TIMEOUT_CYC.
  - Ports: `clock`, `resetn`, `clear`, `enable`, output `expired` pulse.
  - Counter width $clog2(TIMEOUT_CYC+1); held at 0 when TIMEOUT_CYC=0.

## Test plan

Default parameters unless stated, with TIMEOUT_CYC=1000, bytes spaced 20 cycles.

- Frame 12 34 56 78 03, `cmd_ready`=1 → `operands`=0x12345678, `opcode`=0x03; `cmd_valid` high for 1 cycle starting 2 cycles after the opcode pulse; `state_id` walks 0001→0010→0100→1000→0001.
- `cmd_ready`=0, frames AA BB CC DD 01 then 11 22 33 44 02 → first command held; `drop` pulses once after the second opcode. Then raise `cmd_ready` → 0xAABBCCDD/0x01 accepted and `cmd_valid` falls.
- Bytes 12 34, then silence → `timeout_err` pulses 1000 cycles after byte 34, state IDLE. Next frame 01 02 03 04 05 yields 0x01020304/0x05.
- 3 bytes sent, `resetn` pulsed low mid-frame → all outputs 0 and `state_id`=0001 immediately without a clock edge. A following full frame parses correctly.
- `cmd_valid` held, `cmd_ready` raised exactly in the COMMIT cycle of frame 55 66 77 88 09 → old command accepted, new one loaded, no `drop`, `cmd_valid` stays high.
- OPW=8, NOPS=1, bytes AA 05 → `operands`=0xAA, `opcode`=0x05; OPERAND state never entered.
